// File: rtl/multi_dataflow_job_sched.sv
// multi_dataflow_job_sched: round-robin job intake into a FIFO, one dispatched job at a time
// to the controller FSM, with a completion event back to the owning requester.
module multi_dataflow_job_sched #(
    parameter int N_REQ       = 4,
    parameter int QUEUE_DEPTH = 4,
    parameter int JOB_W       = 32
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic [N_REQ-1:0]               req_valid_i,
    input  logic [N_REQ*JOB_W-1:0]         req_job_i,
    output logic [N_REQ-1:0]               req_ready_o,
    output logic                           job_start_o,
    output logic [JOB_W-1:0]               job_o,
    output logic [$clog2(N_REQ)-1:0]       job_owner_o,
    input  logic                           job_done_i,
    output logic                           busy_o,
    output logic [N_REQ-1:0]               evt_o,
    output logic [$clog2(QUEUE_DEPTH):0]   queue_count_o
);
    localparam int OW = $clog2(N_REQ);
    localparam int AW = $clog2(QUEUE_DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {IDLE, START, RUN, DONE} state_t;
    state_t state, state_n;

    logic [JOB_W-1:0] job_mem [QUEUE_DEPTH];
    logic [OW-1:0]    own_mem [QUEUE_DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [CW-1:0]    count;
    logic [OW-1:0]    rr_ptr, grant, idx;
    logic             found, full, push, pop;

    assign full = count == CW'(QUEUE_DEPTH);
    assign push = found;
    assign pop  = state == IDLE && count != '0;

    // search starts at rr_ptr and wraps, so the most recent winner has lowest priority
    always_comb begin
        req_ready_o = '0;
        grant       = '0;
        idx         = '0;
        found       = 1'b0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = OW'((int'(rr_ptr) + k) % N_REQ);
            if (!found && !full && !rst_i && req_valid_i[idx]) begin
                found            = 1'b1;
                grant            = idx;
                req_ready_o[idx] = 1'b1;
            end
        end
    end

    always_comb begin
        state_n = (state == IDLE && count != '0)   ? START :
                  (state == START)                 ? RUN   :
                  (state == RUN && job_done_i)     ? DONE  :
                  (state == DONE)                  ? IDLE  : state;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) state <= IDLE;
        else       state <= state_n;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count       <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            rr_ptr      <= '0;
            job_o       <= '0;
            job_owner_o <= '0;
        end else begin
            count <= count + CW'(push) - CW'(pop);
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
                rr_ptr <= OW'((int'(grant) + 1) % N_REQ);
            end
            if (pop) begin
                rd_ptr      <= rd_ptr + AW'(1);
                job_o       <= job_mem[rd_ptr];
                job_owner_o <= own_mem[rd_ptr];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            job_mem[wr_ptr] <= req_job_i[int'(grant)*JOB_W +: JOB_W];
            own_mem[wr_ptr] <= grant;
        end
    end

    assign job_start_o   = state == START;
    assign busy_o        = state != IDLE;
    assign evt_o         = (state == DONE) ? N_REQ'(1) << job_owner_o : '0;
    assign queue_count_o = count;
endmodule

// File: tb/tb_multi_dataflow_job_sched.sv
// tb_multi_dataflow_job_sched: directed and random stimulus checked cycle by cycle against a
// queue-based reference model of the scheduler.
module tb_multi_dataflow_job_sched;
    localparam int N  = 4;
    localparam int QD = 4;
    localparam int JW = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [N-1:0]  valid = '0;
    logic [N*JW-1:0] jobs = '0;
    logic          done = 1'b0;
    logic [N-1:0]  ready, evt;
    logic          start, busy;
    logic [JW-1:0] job;
    logic [1:0]    owner;
    logic [2:0]    count;

    multi_dataflow_job_sched #(.N_REQ(N), .QUEUE_DEPTH(QD), .JOB_W(JW)) dut (
        .clk_i(clk), .rst_i(rst), .req_valid_i(valid), .req_job_i(jobs), .req_ready_o(ready),
        .job_start_o(start), .job_o(job), .job_owner_o(owner), .job_done_i(done),
        .busy_o(busy), .evt_o(evt), .queue_count_o(count)
    );

    always #5 clk = ~clk;

    typedef struct {int own; logic [JW-1:0] job;} ent_t;
    ent_t q[$];
    int rr = 0, phase = 0, cur_own = 0;
    logic [JW-1:0] cur_job = '0;
    int n_vec = 0, n_err = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [N*JW-1:0] rnd_jobs();
        logic [N*JW-1:0] r;
        for (int i = 0; i < N; i++) r[i*JW +: JW] = $urandom;
        return r;
    endfunction

    // phase: 0 idle, 1 start pulse, 2 waiting for done, 3 completion event
    task automatic step(input logic [N-1:0] v, input logic [N*JW-1:0] j, input logic d, input logic r);
        int g;
        ent_t e;
        valid = v; jobs = j; done = d; rst = r;
        @(negedge clk);
        g = -1;
        if (!r && q.size() < QD)
            for (int k = 0; k < N; k++)
                if (g < 0 && v[(rr + k) % N]) g = (rr + k) % N;
        check("ready", 64'(ready), (g < 0) ? 64'd0 : 64'd1 << g);
        check("start", 64'(start), 64'(phase == 1));
        check("busy",  64'(busy),  64'(phase != 0));
        check("evt",   64'(evt),   (phase == 3) ? 64'd1 << cur_own : 64'd0);
        check("count", 64'(count), 64'(q.size()));
        check("job",   64'(job),   64'(cur_job));
        check("owner", 64'(owner), 64'(cur_own));
        @(posedge clk);
        if (r) begin
            q.delete(); rr = 0; phase = 0; cur_own = 0; cur_job = '0;
        end else begin
            if (phase == 0 && q.size() != 0) begin
                e = q.pop_front(); cur_own = e.own; cur_job = e.job; phase = 1;
            end else if (phase == 1) phase = 2;
            else if (phase == 2 && d) phase = 3;
            else if (phase == 3) phase = 0;
            if (g >= 0) begin
                e.own = g; e.job = j[g*JW +: JW];
                q.push_back(e);
                rr = (g + 1) % N;
            end
        end
        #1;
    endtask

    initial begin
        logic [N*JW-1:0] cafe;
        cafe = '0;
        cafe[2*JW +: JW] = 32'hCAFE0000;
        #1;
        repeat (2) step('0, '0, 1'b0, 1'b1);
        // single job from requester 2
        step(4'b0100, cafe, 1'b0, 1'b0);
        repeat (4) step('0, '0, 1'b0, 1'b0);
        step('0, '0, 1'b1, 1'b0);
        repeat (4) step('0, '0, 1'b0, 1'b0);
        // spurious done while idle
        repeat (3) step('0, '0, 1'b1, 1'b0);
        // all requesters valid with done held off: fills the FIFO, then drain one
        repeat (10) step('1, rnd_jobs(), 1'b0, 1'b0);
        step('1, rnd_jobs(), 1'b1, 1'b0);
        repeat (8) step('1, rnd_jobs(), 1'b0, 1'b0);
        // reset while running with a full queue
        step('1, rnd_jobs(), 1'b0, 1'b1);
        repeat (6) step('0, '0, 1'b0, 1'b0);
        // back-to-back jobs with done held high
        step(4'b1011, rnd_jobs(), 1'b1, 1'b0);
        step(4'b1011, rnd_jobs(), 1'b1, 1'b0);
        step(4'b1011, rnd_jobs(), 1'b1, 1'b0);
        repeat (16) step('0, '0, 1'b1, 1'b0);
        for (int i = 0; i < 3000; i++)
            step(N'($urandom), rnd_jobs(), ($urandom_range(0, 3) == 0), ($urandom_range(0, 149) == 0));
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
